int_dump: RTL and testbench
===========================

// Module: int_dump
// PURPOSE
//  Integrate-and-dump decimator directly upstream of the saturating requantizer.
//  Sums a run-time programmable number of signed input samples and emits one wide sum per epoch.
//  The output is fed, with its valid strobe, into the requantizer's in/WE.
//  It sits after the channel mixer, in the correlator/decimation chain.
// PARAMETERS
//  IN_WIDTH   8   signed input sample width
//  ACC_WIDTH  24  accumulator/output width; must be >= IN_WIDTH
//  CNT_WIDTH  16  epoch counter width; max epoch = 2^CNT_WIDTH samples
// PORTS
//  clk     in   1          single clock, all logic on posedge
//  resetn  in   1          asynchronous active-low reset
//  WE      in   1          input sample strobe; in is accepted only when WE=1
//  in      in   IN_WIDTH   signed two's-complement sample
//  len     in   CNT_WIDTH  epoch length minus one (N-1); 0 = dump every sample
//  sync    in   1          restart epoch: discard partial sum, clear counter
//  valid   out  1          one-cycle pulse, out holds a new sum
//  out     out  ACC_WIDTH  signed epoch sum, held until next dump
//  ovf     out  1          sticky accumulator overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (resetn=0, async): acc=0, cnt=0, len_sh=0, out=0, valid=0, ovf=0; outputs remain there until first dump.
//  Samples: in is sign-extended to ACC_WIDTH. Addition wraps modulo 2^ACC_WIDTH; no saturation here (the downstream block saturates).
//  Epoch length: len is sampled into len_sh on the first accepted sample of each epoch (cnt==0 & WE).
//   Effective limit L = (cnt==0) ? len : len_sh.
//   A len change mid-epoch takes effect from the next epoch.
//  Per accepted sample (WE=1, sync=0):
//   cnt!=L: acc <= acc+sext(in), cnt <= cnt+1.
//   cnt==L: out <= acc+sext(in), valid <= 1 next cycle, acc <= 0, cnt <= 0.
//  Latency: valid and out update 1 clk after the WE of the epoch's last sample.
//  valid is otherwise 0. WE gaps of any length are allowed; the sum is unaffected.
//  sync=1: acc and cnt are cleared. No dump is produced for the partial epoch.
//   sync with WE in the same cycle: that sample becomes sample 0 of the new epoch, so acc <= sext(in), cnt <= 1.
//   If len==0, it dumps immediately.
//   out is unaffected by sync (keeps last sum).
//  len=0: pure pass-through with sign extension; valid = WE delayed 1 clk.
//  cnt never exceeds len_sh. A counter wrap is impossible by construction.
//  Reset asserted mid-epoch: partial sum is lost; the first post-reset sample starts a new epoch.
// CONFIGURATION
//  Macro INT_DUMP_OVF_EN:
//   Defined: ovf sets when any accumulate or dump addition overflows signed ACC_WIDTH (operand signs equal, result sign differs).
//    ovf is sticky and is cleared only by resetn or sync.
//    If sync and overflow occur in the same cycle, sync wins for the old epoch; the new sample's add is then checked.
//   Not defined: ovf tied 0 and no overflow logic is synthesised. The port is present in both builds.
// STRUCTURE
//  Package int_dump_pkg: typedefs for the accumulator type (logic signed [ACC_WIDTH-1:0]) and the counter type.
//   Also a sext function IN_WIDTH->ACC_WIDTH, shared with the requantizer glue.
//  No sub-module. Counter, accumulator, len shadow and output register stay in one always_ff with async reset.
//  The valid pulse is a plain registered strobe and does not use the latency block.
// TESTING
//  1. len=3, WE=1 continuous, in=+1 -> valid every 4th clk, out=4; out holds between pulses.
//  2. len=0, in sequence -128,+127,-1 -> out -128,+127,-1 (sign-extended), 1 clk after each WE.
//  3. len=3, WE pattern 1,0,0,1,1,0,1, in=+5 -> a single valid, out=20, 1 clk after the 4th accepted sample.
//  4. len=7, after 3 samples of +10, pulse sync with WE and in=+2 -> no dump for the partial epoch.
//     The next dump is out=2+7*in_rest; with in_rest=+1 -> out=9.
//  5. len=3, change len to 1 after sample 1 -> current epoch still dumps after 4 samples; following epochs dump every 2.
//  6. ACC_WIDTH=10, len=7, in=+127 x8, macro defined -> out=-8 (1016 wrapped), ovf=1 sticky.
//     sync clears ovf. Without the macro -> out=-8, ovf=0.
//  Also assert resetn low mid-epoch -> all outputs 0 immediately; the next 4 samples (len=3) give a clean sum.

Source files
------------

// File: rtl/int_dump_pkg.sv
// Shared types and helpers for the integrate-and-dump decimator.
// The sext helper is also used by the requantizer glue, so it lives here
// rather than inside the decimator.
package int_dump_pkg;

    localparam int IN_WIDTH  = 8;
    localparam int ACC_WIDTH = 24;
    localparam int CNT_WIDTH = 16;

    typedef logic signed [IN_WIDTH-1:0]  smp_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic        [CNT_WIDTH-1:0] cnt_t;

    // Sign-extend one input sample to accumulator width.
    function automatic acc_t sext(input smp_t x);
        return acc_t'(x);
    endfunction

endpackage

// File: rtl/int_dump_if.sv
// Sample/dump bus of the integrate-and-dump decimator.
// Strobe semantics: the sample on 'in' is consumed on every rising clock
// edge where WE=1. There is no back-pressure, so the source never waits.
// 'valid' is a one-cycle pulse marking a new sum on 'out'. 'out' then holds
// that sum until the next dump. 'sync' restarts the epoch and needs no WE.
interface int_dump_if #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
);
    logic                        WE;
    logic signed [IN_WIDTH-1:0]  in;
    logic [CNT_WIDTH-1:0]        len;
    logic                        sync;
    logic                        valid;
    logic signed [ACC_WIDTH-1:0] out;
    logic                        ovf;

    modport master (output WE, in, len, sync, input valid, out, ovf);
    modport slave  (input WE, in, len, sync, output valid, out, ovf);
endinterface

// File: rtl/int_dump.sv
// Integrate-and-dump decimator.
// It sums a programmable number of signed samples (len+1) and emits one
// wide sum per epoch. Addition wraps; the downstream requantizer saturates.
// Optional macro INT_DUMP_OVF_EN enables the sticky signed-overflow flag.
// Without the macro, ovf is tied to 0.
module int_dump
    import int_dump_pkg::*;
#(
    parameter int IN_WIDTH  = int_dump_pkg::IN_WIDTH,
    parameter int ACC_WIDTH = int_dump_pkg::ACC_WIDTH,
    parameter int CNT_WIDTH = int_dump_pkg::CNT_WIDTH
) (
    input  logic      clk,
    input  logic      resetn,
    int_dump_if.slave bus
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        r_len_sh;
    logic                        r_valid;

    logic signed [ACC_WIDTH-1:0] w_sext;
    logic signed [ACC_WIDTH-1:0] w_acc_eff;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0]        w_cnt_eff;
    logic [CNT_WIDTH-1:0]        w_lim;
    logic                        w_last;

    assign w_sext    = ACC_WIDTH'($signed(bus.in));
    // sync discards the partial epoch before a same-cycle sample is added.
    // The sample then becomes sample 0 of the new epoch.
    assign w_cnt_eff = bus.sync ? '0 : r_cnt;
    assign w_acc_eff = bus.sync ? '0 : r_acc;
    // The first sample of an epoch uses the live len. Later samples use the
    // shadow copy, so a len change mid-epoch waits for the next epoch.
    assign w_lim     = (w_cnt_eff == '0) ? bus.len : r_len_sh;
    assign w_sum     = w_acc_eff + w_sext;
    assign w_last    = (w_cnt_eff == w_lim);

    // Counter, accumulator, len shadow and the registered dump outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_len_sh <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.sync) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (bus.WE) begin
                if (w_cnt_eff == '0) begin
                    r_len_sh <= bus.len;
                end
                if (w_last) begin
                    r_out   <= w_sum;
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_eff + 1'b1;
                end
            end
        end
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;

`ifdef INT_DUMP_OVF_EN
    logic r_ovf;
    logic w_ovf_add;

    // Overflow occurs when both operands have the same sign and the result
    // sign differs. The check covers accumulate and dump additions alike.
    assign w_ovf_add = (w_acc_eff[ACC_WIDTH-1] == w_sext[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != w_acc_eff[ACC_WIDTH-1]);

    // Sticky flag. sync clears it, and a same-cycle sample is checked again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (bus.WE && w_ovf_add) begin
            r_ovf <= 1'b1;
        end else if (bus.sync) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_int_dump.sv
// Directed bench for int_dump.
// A main instance (24-bit accumulator) runs a vector table and hand-written
// reset sequences. A 10-bit instance covers wrap and overflow.
module tb_int_dump;

    localparam int OVF_EXP =
`ifdef INT_DUMP_OVF_EN
        1;
`else
        0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int_dump_if #(.IN_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(16)) bus ();
    int_dump_if #(.IN_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(16)) bus10 ();

    int_dump #(.IN_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    int_dump #(.IN_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(16)) dut10 (
        .clk(clk), .resetn(resetn), .bus(bus10)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        logic              we;
        logic signed [7:0] din;
        logic [15:0]       len;
        logic              sync;
        logic              exp_valid;
        logic signed [23:0] exp_out;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 ns after a rising edge, and outputs are sampled there.
    task automatic drive(input logic we, input logic signed [7:0] din,
                         input logic [15:0] len, input logic sync);
        bus.WE = we; bus.in = din; bus.len = len; bus.sync = sync;
        @(posedge clk); #1;
    endtask

    task automatic drive10(input logic we, input logic signed [7:0] din,
                           input logic [15:0] len, input logic sync);
        bus10.WE = we; bus10.in = din; bus10.len = len; bus10.sync = sync;
        @(posedge clk); #1;
    endtask

    task automatic add(input logic we, input int din, input int len,
                       input logic sync, input logic ev, input int eo);
        vec_t v;
        v.we = we; v.din = 8'(din); v.len = 16'(len); v.sync = sync;
        v.exp_valid = ev; v.exp_out = 24'(eo);
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    // Every dump on the main instance must match the next queued sum.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.valid === 1'b1) begin
            logic [23:0] e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got out=%0d expected no dump",
                         $signed(bus.out));
            end else begin
                e = exp_q.pop_front();
                check("sb_out", int'($signed(bus.out)), int'($signed(e)));
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        resetn = 1'b0;
        bus.WE = 1'b0; bus.in = '0; bus.len = '0; bus.sync = 1'b0;
        bus10.WE = 1'b0; bus10.in = '0; bus10.len = '0; bus10.sync = 1'b0;

        // 1: len=3, continuous +1 -> dump of 4 every 4th sample
        for (int i = 0; i < 8; i++) add(1, 1, 3, 0, (i % 4) == 3, (i < 3) ? 0 : 4);
        // 2: len=0 pass-through with sign extension
        add(1, -128, 0, 0, 1, -128);
        add(1,  127, 0, 0, 1,  127);
        add(1,   -1, 0, 0, 1,   -1);
        add(0,    0, 0, 0, 0,   -1);
        // 3: len=3, WE gaps 1,0,0,1,1,0,1 with +5 -> single dump of 20
        add(1, 5, 3, 0, 0, -1); add(0, 5, 3, 0, 0, -1); add(0, 5, 3, 0, 0, -1);
        add(1, 5, 3, 0, 0, -1); add(1, 5, 3, 0, 0, -1); add(0, 5, 3, 0, 0, -1);
        add(1, 5, 3, 0, 1, 20);
        // 4: len=7, 3x+10, then sync+WE(+2), then 7x+1 -> 9
        for (int i = 0; i < 3; i++) add(1, 10, 7, 0, 0, 20);
        add(1, 2, 7, 1, 0, 20);
        for (int i = 0; i < 6; i++) add(1, 1, 7, 0, 0, 20);
        add(1, 1, 7, 0, 1, 9);
        // 5: len 3 -> 1 after the first sample; epoch still 4 long, then 2
        add(1, 1, 3, 0, 0, 9);
        add(1, 2, 1, 0, 0, 9);
        add(1, 3, 1, 0, 0, 9);
        add(1, 4, 1, 0, 1, 10);
        add(1, 5, 1, 0, 0, 10);
        add(1, 6, 1, 0, 1, 11);
        add(1, 7, 1, 0, 0, 11);
        add(1, 8, 1, 0, 1, 15);
        // sync alone keeps out; sync+WE with len=0 dumps at once
        add(0, 0, 3, 1, 0, 15);
        add(1, 50, 3, 0, 0, 15);
        add(1, 50, 3, 0, 0, 15);
        add(1, -3, 0, 1, 1, -3);
        add(1,  4, 0, 0, 1,  4);
        add(0,  0, 3, 0, 0,  4);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   int'(bus.valid), 0);
        check("rst_out",     int'($signed(bus.out)), 0);
        check("rst_ovf",     int'(bus.ovf), 0);
        check("rst10_out",   int'($signed(bus10.out)), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_out);
            drive(vecs[i].we, vecs[i].din, vecs[i].len, vecs[i].sync);
            check($sformatf("v%0d_valid", i), int'(bus.valid), int'(vecs[i].exp_valid));
            check($sformatf("v%0d_out", i), int'($signed(bus.out)), int'(vecs[i].exp_out));
            check($sformatf("v%0d_ovf", i), int'(bus.ovf), 0);
        end

        // reset mid-epoch: outputs clear at once, and the partial sum is lost
        drive(1, 9, 3, 0);
        drive(1, 9, 3, 0);
        resetn = 1'b0;
        #2;
        check("async_rst_out",   int'($signed(bus.out)), 0);
        check("async_rst_valid", int'(bus.valid), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(24'd24);
            drive(1, 6, 3, 0);
            check($sformatf("post_rst%0d_valid", i), int'(bus.valid), (i == 3) ? 1 : 0);
            check($sformatf("post_rst%0d_out", i), int'($signed(bus.out)), (i == 3) ? 24 : 0);
        end
        drive(0, 0, 3, 0);

        // 10-bit accumulator: 8 x +127 = 1016 wraps to -8
        for (int i = 0; i < 8; i++) begin
            drive10(1, 127, 7, 0);
            if (i == 3) check("acc10_ovf_before", int'(bus10.ovf), 0);
            if (i == 4) check("acc10_ovf_set", int'(bus10.ovf), OVF_EXP);
        end
        check("acc10_valid", int'(bus10.valid), 1);
        check("acc10_out",   int'($signed(bus10.out)), -8);
        check("acc10_ovf",   int'(bus10.ovf), OVF_EXP);
        drive10(0, 0, 7, 0);
        drive10(0, 0, 7, 0);
        check("acc10_hold_valid", int'(bus10.valid), 0);
        check("acc10_hold_out",   int'($signed(bus10.out)), -8);
        check("acc10_ovf_sticky", int'(bus10.ovf), OVF_EXP);
        drive10(0, 0, 7, 1);
        check("acc10_sync_ovf", int'(bus10.ovf), 0);
        check("acc10_sync_out", int'($signed(bus10.out)), -8);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
